// File: rtl/io_uart_leds_responder_if.sv
// io_uart_leds_responder_if: core IO bus (address, store data, store strobe, combinational read data)
interface io_uart_leds_responder_if;
  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;
  modport master (output IO_mem_addr, output IO_mem_wdata, output IO_mem_wr, input IO_mem_rdata);
  modport slave (input IO_mem_addr, input IO_mem_wdata, input IO_mem_wr, output IO_mem_rdata);
endinterface

// File: rtl/io_uart_leds_responder.sv
// io_uart_leds_responder: IO-bus target with an LED register and a FIFO-buffered 8N1 UART transmitter
module io_uart_leds_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  io_uart_leds_responder_if.slave      bus,
  output logic [LED_WIDTH-1:0]         leds,
  output logic                         uart_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic [LED_WIDTH-1:0] leds_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q;
  logic                 io, we, sel_led, sel_data, sel_stat;
  logic                 full, empty, push, pop, ovf_set, ovf_clr, last;
  logic [31:0]          status;
  assign io       = bus.IO_mem_addr[22];
  assign sel_led  = io & bus.IO_mem_addr[2];
  assign sel_data = io & bus.IO_mem_addr[3];
  assign sel_stat = io & bus.IO_mem_addr[4];
  assign we       = resetn & bus.IO_mem_wr;
  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign empty    = cnt_q == '0;
  // Fullness is judged before the edge, so a same-cycle pop never rescues a push.
  assign push     = we & sel_data & ~full;
  assign ovf_set  = we & sel_data & full;
  assign ovf_clr  = we & sel_stat & bus.IO_mem_wdata[3];
  assign pop      = (state_q == IDLE) & ~empty;
  assign last     = tmr_q == TW'(CLKS_PER_BIT - 1);
  assign status   = {16'b0, 8'(cnt_q), 4'b0, ovf_q, empty, full, state_q != IDLE};
  assign bus.IO_mem_rdata = (sel_led ? 32'(leds_q) : 32'b0) | (sel_stat ? status : 32'b0);
  assign leds     = leds_q;
  assign uart_txd = txd_q;
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          state_d = START;
          shift_d = mem_q[rp_q];
          tmr_d   = '0;
          idx_d   = '0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        tmr_d = last ? '0 : tmr_q + 1'b1;
        if (last) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        tmr_d = last ? '0 : tmr_q + 1'b1;
        if (last) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          state_d = idx_q == 3'd7 ? STOP : DATA;
          txd_d   = idx_q == 3'd7 ? 1'b1 : shift_q[1];
        end
      end
      STOP: begin
        tmr_d = last ? '0 : tmr_q + 1'b1;
        if (last) state_d = IDLE;
        txd_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      leds_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (we & sel_led) leds_q <= bus.IO_mem_wdata[LED_WIDTH-1:0];
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.IO_mem_wdata[7:0];
  end
endmodule
